// File: rtl/ariane_pkg.sv
// Shared issue-window types: decoded entry, functional-unit encoding and window slot.
package ariane_pkg;

    localparam int unsigned LSU_WINDOW_DEPTH = 4;
    localparam int unsigned LSU_MAX_BYPASS   = 3;

    typedef enum logic [2:0] {
        FU_NONE   = 3'd0,
        LOAD      = 3'd1,
        STORE     = 3'd2,
        ALU       = 3'd3,
        CTRL_FLOW = 3'd4,
        MULT      = 3'd5
    } fu_t;

    typedef struct packed {
        logic [15:0] pc;
        fu_t         fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
        logic              valid;
    } window_slot_t;

    function automatic logic is_mem(input fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

    function automatic logic slot_is_cf(input window_slot_t s);
        return s.is_ctrl_flow || (s.sbe.fu == CTRL_FLOW);
    endfunction

endpackage

// File: rtl/issue_hazard_chk.sv
// RAW/WAR/WAW register hazard between a bypass candidate and one older entry.
module issue_hazard_chk
    import ariane_pkg::*;
(
    input  scoreboard_entry_t cand_i,
    input  scoreboard_entry_t older_i,
    output logic              hazard_o
);

    logic raw, war, waw;
    logic unused_fields;

    assign raw = (cand_i.rs1 == older_i.rd) || (cand_i.rs2 == older_i.rd);
    assign war = (cand_i.rd == older_i.rs1) || (cand_i.rd == older_i.rs2);
    assign waw = (cand_i.rd == older_i.rd);

    assign hazard_o = raw || war || waw;

    assign unused_fields = ^{cand_i.pc, cand_i.fu, older_i.pc, older_i.fu};

endmodule

// File: rtl/lsu_issue_scheduler.sv
// Age-ordered issue window that lets independent ALU work overtake a stalled
// memory op at the head, with a bounded number of consecutive bypasses.
module lsu_issue_scheduler
    import ariane_pkg::*;
#(
    parameter int unsigned WINDOW_DEPTH = LSU_WINDOW_DEPTH,
    parameter int unsigned MAX_BYPASS   = LSU_MAX_BYPASS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              debug_req_i,
    input  scoreboard_entry_t issue_entry_i,
    input  logic              issue_entry_valid_i,
    input  logic              is_ctrl_flow_i,
    output logic              issue_instr_ack_o,
    output scoreboard_entry_t issue_entry_o,
    output logic              issue_entry_valid_o,
    output logic              is_ctrl_flow_o,
    input  logic              issue_instr_ack_i,
    input  logic              lsu_ready_i
);

    localparam int unsigned CW = $clog2(WINDOW_DEPTH + 1);
    localparam int unsigned IW = $clog2(WINDOW_DEPTH);
    localparam int unsigned BW = (MAX_BYPASS > 0) ? $clog2(MAX_BYPASS + 1) : 1;

    window_slot_t         win_q [WINDOW_DEPTH];
    window_slot_t         win_d [WINDOW_DEPTH];
    logic [CW-1:0]        count_q, count_d;
    logic [BW-1:0]        bypass_cnt_q, bypass_cnt_d;
    logic [IW-1:0]        sel;
    logic [CW-1:0]        push_idx;
    logic [WINDOW_DEPTH-1:0] haz_any;
    logic                 bypass_ok, found, cf_seen;
    logic                 valid_int, push, pop;

    assign haz_any[0] = 1'b0;

    for (genvar k = 1; k < WINDOW_DEPTH; k++) begin : g_cand
        logic [k-1:0] haz;
        for (genvar j = 0; j < k; j++) begin : g_older
            issue_hazard_chk u_chk (
                .cand_i   (win_q[k].sbe),
                .older_i  (win_q[j].sbe),
                .hazard_o (haz[j])
            );
        end
        assign haz_any[k] = |haz;
    end

    // Oldest eligible slot wins; a control-flow entry blocks everything younger.
    always_comb begin
        bypass_ok = win_q[0].valid && is_mem(win_q[0].sbe.fu) && !lsu_ready_i
                    && !debug_req_i && (bypass_cnt_q < BW'(MAX_BYPASS));
        sel     = '0;
        found   = 1'b0;
        cf_seen = slot_is_cf(win_q[0]);
        for (int unsigned k = 1; k < WINDOW_DEPTH; k++) begin
            if (bypass_ok && !found && win_q[k].valid && !cf_seen && !haz_any[k]
                && !is_mem(win_q[k].sbe.fu) && !slot_is_cf(win_q[k])) begin
                sel   = IW'(k);
                found = 1'b1;
            end
            cf_seen = cf_seen || slot_is_cf(win_q[k]);
        end
    end

    assign valid_int           = (count_q != '0) && !rst_i;
    assign issue_entry_valid_o = valid_int;
    assign issue_entry_o       = valid_int ? win_q[sel].sbe : '0;
    assign is_ctrl_flow_o      = valid_int ? win_q[sel].is_ctrl_flow : 1'b0;
    assign issue_instr_ack_o   = issue_entry_valid_i && (count_q < CW'(WINDOW_DEPTH))
                                 && !flush_i && !rst_i;

    assign push = issue_instr_ack_o;
    assign pop  = issue_instr_ack_i && valid_int && !flush_i;

    always_comb begin
        win_d        = win_q;
        count_d      = count_q;
        bypass_cnt_d = bypass_cnt_q;
        push_idx     = count_q;

        if (pop) begin
            for (int unsigned i = 0; i < WINDOW_DEPTH - 1; i++) begin
                if (IW'(i) >= sel) begin
                    win_d[i] = win_q[i+1];
                end
            end
            win_d[WINDOW_DEPTH-1].valid = 1'b0;
            push_idx = count_q - CW'(1);
            if (sel == '0) begin
                bypass_cnt_d = '0;
            end else if (bypass_cnt_q < BW'(MAX_BYPASS)) begin
                bypass_cnt_d = bypass_cnt_q + BW'(1);
            end
        end

        if (push) begin
            win_d[IW'(push_idx)] = '{sbe: issue_entry_i, is_ctrl_flow: is_ctrl_flow_i, valid: 1'b1};
        end

        count_d = count_q + CW'(push) - CW'(pop);

        if (flush_i) begin
            count_d      = '0;
            bypass_cnt_d = '0;
            for (int unsigned i = 0; i < WINDOW_DEPTH; i++) begin
                win_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q      <= '0;
            bypass_cnt_q <= '0;
            for (int unsigned i = 0; i < WINDOW_DEPTH; i++) begin
                win_q[i].valid <= 1'b0;
            end
        end else begin
            count_q      <= count_d;
            bypass_cnt_q <= bypass_cnt_d;
            win_q        <= win_d;
        end
    end

endmodule
